handshake_rx: RTL and testbench

HANDSHAKE_RX -- requirements
Module: handshake_rx

---
 rtl/usb_pkg.sv | 51 +++++
 rtl/handshake_rx.sv | 163 ++++++++++++++++
 tb/tb_handshake_rx.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB low-speed/full-speed definitions for the handshake receive and
// transmit blocks: PID codes, receiver states, result codes and SYNC constants.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  // SYNC as it appears on the wire, LSB first: seven 0s then a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam int         SYNC_ZEROS   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SYNC,
    ST_PID,
    ST_EOP
  } rxStateE;

  typedef enum logic [2:0] {
    RES_ACK,
    RES_NAK,
    RES_STALL,
    RES_NYET,
    RES_PIDERR,
    RES_TIMEOUT
  } resultE;

  function automatic resultE decodeHandshake(input logic [7:0] pidByte);
    resultE res;
    res = RES_PIDERR;
    if (pidByte[7:4] == ~pidByte[3:0]) begin
      case (pidByte[3:0])
        PID_ACK:   res = RES_ACK;
        PID_NAK:   res = RES_NAK;
        PID_STALL: res = RES_STALL;
        PID_NYET:  res = RES_NYET;
        default:   res = RES_PIDERR;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/handshake_rx.sv
// Receives the handshake packet answering our data packet: hunts for SYNC,
// collects the PID byte, validates EOP and reports one registered result.
module handshake_rx
  import usb_pkg::*;
#(
  parameter int TIMEOUT_BITS   = 18,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       useClk,
  input  logic       rstN,
  input  logic       checkData,
  input  logic       rxBit,
  input  logic       rxSe0,
  input  logic       expectHandshake,
  output logic       busy,
  output logic       resultValid,
  output logic [3:0] pid,
  output logic       gotAck,
  output logic       gotNak,
  output logic       gotStall,
  output logic       gotNyet,
  output logic       pidError,
  output logic       timeout
);

  localparam int              TO_W     = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_BITS);
  localparam logic [2:0]      ZERO_SAT = 3'(SYNC_ZEROS);

  rxStateE         stateReg, stateNext;
  logic [2:0]      zeroCntReg, zeroCntNext;
  logic [TO_W-1:0] toCntReg, toCntNext, toInc;
  logic [2:0]      bitCntReg, bitCntNext;
  logic [1:0]      eopCntReg, eopCntNext;
  logic [7:0]      shiftReg, shiftNext;
  logic [3:0]      pidReg, pidNext;
  logic            doneReg, doneNext;
  resultE          resNext;
  logic [5:0]      flagsReg, flagsNext;

  always_comb begin
    stateNext   = stateReg;
    zeroCntNext = zeroCntReg;
    toCntNext   = toCntReg;
    bitCntNext  = bitCntReg;
    eopCntNext  = eopCntReg;
    shiftNext   = shiftReg;
    pidNext     = pidReg;
    doneNext    = 1'b0;
    resNext     = RES_PIDERR;
    toInc       = toCntReg + 1'b1;

    case (stateReg)
      ST_IDLE: begin
        if (expectHandshake) begin
          stateNext = ST_HUNT;
          toCntNext = '0;
        end
      end
      ST_HUNT, ST_SYNC: begin
        if (checkData) begin
          toCntNext = toInc;
          if (stateReg == ST_HUNT) begin
            if (!rxBit && !rxSe0) begin
              stateNext   = ST_SYNC;
              zeroCntNext = 3'd1;
            end
          end else if (rxSe0) begin
            stateNext = ST_HUNT;
          end else if (!rxBit) begin
            if (zeroCntReg != ZERO_SAT) zeroCntNext = zeroCntReg + 3'd1;
          end else if (int'(zeroCntReg) >= SYNC_MIN_ZEROS) begin
            stateNext  = ST_PID;
            bitCntNext = '0;
          end else begin
            stateNext = ST_HUNT;
          end
          // A SYNC that completes on the last allowed strobe still wins.
          if (stateNext != ST_PID && toInc == TO_LIMIT) begin
            stateNext = ST_IDLE;
            doneNext  = 1'b1;
            resNext   = RES_TIMEOUT;
          end
        end
      end
      ST_PID: begin
        if (checkData) begin
          if (rxSe0) begin
            stateNext = ST_IDLE;
            doneNext  = 1'b1;
          end else begin
            shiftNext  = {rxBit, shiftReg[7:1]};
            bitCntNext = bitCntReg + 3'd1;
            if (bitCntReg == 3'd7) begin
              stateNext  = ST_EOP;
              eopCntNext = '0;
            end
          end
        end
      end
      ST_EOP: begin
        if (checkData) begin
          if (eopCntReg != 2'd2) begin
            if (rxSe0) eopCntNext = eopCntReg + 2'd1;
            else       doneNext   = 1'b1;
          end else begin
            doneNext = 1'b1;
            if (!rxSe0 && rxBit) resNext = decodeHandshake(shiftReg);
          end
          if (doneNext) begin
            stateNext = ST_IDLE;
            pidNext   = shiftReg[3:0];
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    flagsNext = '0;
    if (doneNext) begin
      case (resNext)
        RES_ACK:     flagsNext = 6'b100000;
        RES_NAK:     flagsNext = 6'b010000;
        RES_STALL:   flagsNext = 6'b001000;
        RES_NYET:    flagsNext = 6'b000100;
        RES_TIMEOUT: flagsNext = 6'b000001;
        default:     flagsNext = 6'b000010;
      endcase
    end
  end

  always_ff @(posedge useClk or negedge rstN) begin
    if (!rstN) begin
      stateReg   <= ST_IDLE;
      zeroCntReg <= '0;
      toCntReg   <= '0;
      bitCntReg  <= '0;
      eopCntReg  <= '0;
      shiftReg   <= '0;
      pidReg     <= '0;
      doneReg    <= 1'b0;
      flagsReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      zeroCntReg <= zeroCntNext;
      toCntReg   <= toCntNext;
      bitCntReg  <= bitCntNext;
      eopCntReg  <= eopCntNext;
      shiftReg   <= shiftNext;
      pidReg     <= pidNext;
      doneReg    <= doneNext;
      flagsReg   <= flagsNext;
    end
  end

  assign busy        = (stateReg != ST_IDLE);
  assign resultValid = doneReg;
  assign pid         = pidReg;
  assign {gotAck, gotNak, gotStall, gotNyet, pidError, timeout} = flagsReg;

endmodule

// File: tb/tb_handshake_rx.sv
// Self-checking bench for handshake_rx: directed scenarios plus randomized
// packets compared against a packet-level model of the expected outcome.
module tb_handshake_rx;

  logic       useClk = 1'b0;
  logic       rstN = 1'b0;
  logic       checkData = 1'b0;
  logic       rxBit = 1'b1;
  logic       rxSe0 = 1'b0;
  logic       expectHandshake = 1'b0;
  logic       busy, resultValid;
  logic [3:0] pid;
  logic       gotAck, gotNak, gotStall, gotNyet, pidError, timeout;

  int         errors = 0;
  int         checks = 0;
  int         gapHits = 0;
  logic [3:0] expPid = 4'h0;

  handshake_rx #(.TIMEOUT_BITS(18), .SYNC_MIN_ZEROS(5)) dut (
    .useClk(useClk), .rstN(rstN), .checkData(checkData), .rxBit(rxBit),
    .rxSe0(rxSe0), .expectHandshake(expectHandshake), .busy(busy),
    .resultValid(resultValid), .pid(pid), .gotAck(gotAck), .gotNak(gotNak),
    .gotStall(gotStall), .gotNyet(gotNyet), .pidError(pidError), .timeout(timeout)
  );

  always #5 useClk = ~useClk;

  // Outcome codes: 0 ACK, 1 NAK, 2 STALL, 3 NYET, 4 pidError, 5 timeout.
  function automatic int expectCode(input logic [7:0] b, input int eopKind);
    if (eopKind != 0) return 4;
    if (int'(b[7:4]) + int'(b[3:0]) != 15) return 4;
    case (b[3:0])
      4'd2:    return 0;
      4'd10:   return 1;
      4'd14:   return 2;
      4'd6:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [5:0] flagsOf(input int code);
    logic [5:0] top;
    top = 6'b100000;
    return top >> code;
  endfunction

  task automatic arm();
    expectHandshake = 1'b1;
    @(posedge useClk); #1;
    expectHandshake = 1'b0;
  endtask

  // Idle gap cycles carry random line values that must be ignored.
  task automatic strobe(input logic b, input logic s, input int gap, output logic rv);
    for (int i = 0; i < gap; i++) begin
      @(posedge useClk); #1;
      if (resultValid) gapHits++;
    end
    checkData = 1'b1; rxBit = b; rxSe0 = s;
    @(posedge useClk); #1;
    rv = resultValid;
    checkData = 1'b0; rxBit = 1'($urandom); rxSe0 = 1'($urandom);
  endtask

  // kind: 0 good EOP, 1 data on EOP strobe 1, 2 data on strobe 2, 3 SE0 on strobe 3
  task automatic runPacket(input int idle, input int zeros, input logic [7:0] b,
                           input int kind, input int maxGap, output logic [10:0] res,
                           output int early, output logic [1:0] tail);
    logic [1:0] q[$];
    logic rv;
    early = 0; gapHits = 0; res = '0;
    for (int i = 0; i < idle; i++) q.push_back(2'b10);
    for (int i = 0; i < zeros; i++) q.push_back(2'b00);
    q.push_back(2'b10);
    for (int i = 0; i < 8; i++) q.push_back({b[i], 1'b0});
    case (kind)
      0: begin q.push_back(2'b01); q.push_back(2'b01); q.push_back(2'b10); end
      1: q.push_back(2'b00);
      2: begin q.push_back(2'b01); q.push_back(2'b00); end
      default: begin q.push_back(2'b01); q.push_back(2'b01); q.push_back(2'b01); end
    endcase
    arm();
    for (int i = 0; i < q.size(); i++) begin
      strobe(q[i][1], q[i][0], int'($urandom_range(0, maxGap)), rv);
      if (i == q.size() - 1)
        res = {rv, gotAck, gotNak, gotStall, gotNyet, pidError, timeout, pid};
      else if (rv) early++;
    end
    early += gapHits;
    @(posedge useClk); #1;
    tail = {resultValid, busy};
    $display("txn byte=%h kind=%0d idle=%0d zeros=%0d res=%b early=%0d", b, kind, idle, zeros, res, early);
  endtask

  task automatic test_reset();
    #7;
    checks++;
    if ({busy, resultValid, pid, gotAck, gotNak, gotStall, gotNyet, pidError, timeout} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, resultValid, pid, gotAck, gotNak, gotStall, gotNyet, pidError, timeout});
    end
    @(posedge useClk); #1;
    rstN = 1'b1;
    @(posedge useClk); #1;
    checks++;
    if ({busy, resultValid} !== 2'b00) begin
      errors++; $display("FAIL reset_release got=%b exp=00", {busy, resultValid});
    end
  endtask

  task automatic test_ack();
    logic [10:0] r, e; int early; logic [1:0] t;
    runPacket(3, 7, 8'hD2, 0, 2, r, early, t);
    e = {1'b1, flagsOf(expectCode(8'hD2, 0)), 4'h2};
    expPid = 4'h2;
    checks++;
    if (r !== e) begin errors++; $display("FAIL ack_result got=%b exp=%b", r, e); end
    checks++;
    if (early != 0 || t !== 2'b00) begin
      errors++; $display("FAIL ack_pulse early=%0d tail=%b exp early=0 tail=00", early, t);
    end
  endtask

  task automatic test_nak_stall();
    logic [7:0] bytes [2];
    logic [10:0] r, e; int early; logic [1:0] t;
    bytes = '{8'h5A, 8'h1E};
    for (int k = 0; k < 2; k++) begin
      runPacket(3, 7, bytes[k], 0, 1, r, early, t);
      e = {1'b1, flagsOf(expectCode(bytes[k], 0)), bytes[k][3:0]};
      expPid = bytes[k][3:0];
      checks++;
      if (r !== e) begin errors++; $display("FAIL nak_stall_%0d got=%b exp=%b", k, r, e); end
      checks++;
      if (early != 0 || t !== 2'b00) begin
        errors++; $display("FAIL nak_stall_pulse_%0d early=%0d tail=%b exp 0/00", k, early, t);
      end
    end
  endtask

  task automatic test_timeout();
    logic rv; int early; logic [10:0] r, e;
    early = 0; gapHits = 0;
    arm();
    for (int i = 0; i < 18; i++) begin
      strobe(1'b1, 1'b0, 1, rv);
      if (i < 17 && rv) early++;
    end
    r = {rv, gotAck, gotNak, gotStall, gotNyet, pidError, timeout, pid};
    e = {1'b1, flagsOf(5), expPid};
    $display("txn timeout res=%b", r);
    checks++;
    if (r !== e) begin errors++; $display("FAIL timeout_result got=%b exp=%b", r, e); end
    checks++;
    if (early + gapHits != 0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", early + gapHits); end
  endtask

  task automatic test_ignore_arm();
    logic rv; int early; logic [10:0] r, e;
    early = 0; gapHits = 0;
    arm();
    for (int i = 0; i < 10; i++) begin strobe(1'b1, 1'b0, 0, rv); if (rv) early++; end
    arm();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 1'b0, 0, rv);
      if (i < 7 && rv) early++;
    end
    r = {rv, gotAck, gotNak, gotStall, gotNyet, pidError, timeout, pid};
    e = {1'b1, flagsOf(5), expPid};
    $display("txn rearm_timeout res=%b", r);
    checks++;
    if (r !== e || early + gapHits != 0) begin
      errors++; $display("FAIL rearm_ignored got=%b early=%0d exp=%b early=0", r, early + gapHits, e);
    end
  endtask

  task automatic test_pid_errors();
    logic [7:0] bytes [4];
    int kinds [4];
    int zs [4];
    logic [10:0] r, e; int early; logic [1:0] t;
    bytes = '{8'hD3, 8'hD2, 8'hD2, 8'hD2};
    kinds = '{0, 1, 3, 0};
    zs    = '{7, 7, 6, 5};
    for (int k = 0; k < 4; k++) begin
      runPacket(2, zs[k], bytes[k], kinds[k], 1, r, early, t);
      e = {1'b1, flagsOf(expectCode(bytes[k], kinds[k])), bytes[k][3:0]};
      expPid = bytes[k][3:0];
      checks++;
      if (r !== e) begin errors++; $display("FAIL piderr_%0d got=%b exp=%b", k, r, e); end
      checks++;
      if (early != 0 || t !== 2'b00) begin
        errors++; $display("FAIL piderr_pulse_%0d early=%0d tail=%b exp 0/00", k, early, t);
      end
    end
  endtask

  task automatic test_short_sync();
    logic rv; int early; logic [10:0] r, e; logic [7:0] b;
    early = 0; gapHits = 0; b = 8'hD2;
    arm();
    for (int i = 0; i < 3; i++) begin strobe(1'b0, 1'b0, 1, rv); if (rv) early++; end
    strobe(1'b1, 1'b0, 1, rv); if (rv) early++;
    for (int i = 0; i < 4; i++) begin strobe(1'b0, 1'b0, 1, rv); if (rv) early++; end
    strobe(1'b1, 1'b0, 1, rv); if (rv) early++;
    checks++;
    if (busy !== 1'b1 || early + gapHits != 0) begin
      errors++; $display("FAIL short_sync busy=%b early=%0d exp busy=1 early=0", busy, early + gapHits);
    end
    for (int i = 0; i < 7; i++) begin strobe(1'b0, 1'b0, 0, rv); if (rv) early++; end
    strobe(1'b1, 1'b0, 0, rv); if (rv) early++;
    for (int i = 0; i < 3; i++) begin strobe(b[i], 1'b0, 0, rv); if (rv) early++; end
    strobe(1'b0, 1'b1, 0, rv);
    r = {rv, gotAck, gotNak, gotStall, gotNyet, pidError, timeout, pid};
    e = {1'b1, flagsOf(4), expPid};
    $display("txn pid_se0 res=%b", r);
    checks++;
    if (r !== e || early + gapHits != 0) begin
      errors++; $display("FAIL pid_se0 got=%b early=%0d exp=%b early=0", r, early + gapHits, e);
    end
  endtask

  task automatic test_reset_mid();
    logic rv; int early; logic [7:0] b; logic [10:0] r, e; logic [1:0] t;
    early = 0; gapHits = 0; b = 8'hD2;
    arm();
    for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0, 1, rv);
    strobe(1'b1, 1'b0, 1, rv);
    for (int i = 0; i < 4; i++) strobe(b[i], 1'b0, 1, rv);
    checkData = 1'b1; rxBit = b[4]; rxSe0 = 1'b0;
    rstN = 1'b0;
    #2;
    checks++;
    if ({busy, resultValid, pid, gotAck, gotNak, gotStall, gotNyet, pidError, timeout} !== 12'h0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b exp=0", {busy, resultValid, pid, gotAck, gotNak, gotStall, gotNyet, pidError, timeout});
    end
    checkData = 1'b0;
    repeat (3) @(posedge useClk);
    #1;
    rstN = 1'b1;
    expPid = 4'h0;
    for (int i = 5; i < 8; i++) begin strobe(b[i], 1'b0, 1, rv); if (rv) early++; end
    strobe(1'b0, 1'b1, 1, rv); if (rv) early++;
    strobe(1'b0, 1'b1, 1, rv); if (rv) early++;
    strobe(1'b1, 1'b0, 1, rv); if (rv) early++;
    checks++;
    if (early + gapHits != 0 || busy !== 1'b0 || pid !== 4'h0) begin
      errors++; $display("FAIL midreset_idle rv=%0d busy=%b pid=%h exp 0/0/0", early + gapHits, busy, pid);
    end
    runPacket(1, 7, 8'hD2, 0, 1, r, early, t);
    e = {1'b1, flagsOf(0), 4'h2};
    expPid = 4'h2;
    checks++;
    if (r !== e || early != 0) begin
      errors++; $display("FAIL midreset_ack got=%b early=%0d exp=%b early=0", r, early, e);
    end
  endtask

  task automatic test_random();
    logic [7:0] good [4];
    logic [7:0] b;
    int idle, zeros, kind, code;
    logic [10:0] r, e; int early; logic [1:0] t;
    good = '{8'hD2, 8'h5A, 8'h1E, 8'h96};
    for (int n = 0; n < 24; n++) begin
      idle  = int'($urandom_range(0, 4));
      zeros = int'($urandom_range(5, 9));
      b     = ($urandom_range(0, 1) == 0) ? good[$urandom_range(0, 3)] : 8'($urandom);
      kind  = int'($urandom_range(0, 5));
      if (kind > 3) kind = 0;
      runPacket(idle, zeros, b, kind, 3, r, early, t);
      code = expectCode(b, kind);
      e = {1'b1, flagsOf(code), b[3:0]};
      expPid = b[3:0];
      checks++;
      if (r !== e) begin errors++; $display("FAIL random_%0d byte=%h kind=%0d got=%b exp=%b", n, b, kind, r, e); end
      checks++;
      if (early != 0 || t !== 2'b00) begin
        errors++; $display("FAIL random_pulse_%0d early=%0d tail=%b exp 0/00", n, early, t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak_stall();
    test_timeout();
    test_ignore_arm();
    test_pid_errors();
    test_short_sync();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
